// File: rtl/jtag_ir_decoder.sv
// JTAG instruction register: capture/shift/update stages, shift-length checker
// and one-hot decode of the committed instruction into data-register selects.
module jtag_ir_decoder #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 4'b0010,
  parameter logic [IR_WIDTH-1:0] SAMPLE_OP  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] USER_BASE  = 4'b1000,
  parameter int                  NUM_USER   = 2,
  parameter bit                  HAS_IDCODE = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tlr,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic                tdi,
  input  logic [IR_WIDTH-3:0] status_i,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] instr,
  output logic                sel_bypass,
  output logic                sel_extest,
  output logic                sel_idcode,
  output logic                sel_sample,
  output logic [NUM_USER-1:0] sel_user,
  output logic                len_err
);

  localparam int                  CW          = $clog2(IR_WIDTH + 2);
  localparam int                  UW          = IR_WIDTH + 1;
  localparam logic [CW-1:0]       CNT_MAX     = CW'(IR_WIDTH + 1);
  localparam logic [CW-1:0]       CNT_FULL    = CW'(IR_WIDTH);
  localparam logic [IR_WIDTH-1:0] ALL_ONES    = {IR_WIDTH{1'b1}};
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = HAS_IDCODE ? IDCODE_OP : ALL_ONES;
  localparam logic [IR_WIDTH-1:0] RESET_SHIFT = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] shift_reg;
  logic [CW-1:0]       shift_cnt;
  logic [NUM_USER-1:0] user_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= RESET_SHIFT;
      instr     <= RESET_INSTR;
      shift_cnt <= '0;
      len_err   <= 1'b0;
    end else if (tlr) begin
      shift_reg <= RESET_SHIFT;
      instr     <= RESET_INSTR;
      shift_cnt <= '0;
      len_err   <= 1'b0;
    end else begin
      if (capture_ir) begin
        shift_reg <= {status_i, 2'b01};
        shift_cnt <= '0;
      end else if (shift_ir) begin
        shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
        if (shift_cnt != CNT_MAX)
          shift_cnt <= shift_cnt + 1'b1;
      end
      // update samples the pre-edge register, so it composes with capture/shift
      if (update_ir) begin
        instr   <= shift_reg;
        len_err <= (shift_cnt != CNT_FULL);
      end else begin
        len_err <= 1'b0;
      end
    end
  end

  // widened compare so USER_BASE+k never wraps onto a low opcode
  always_comb begin
    user_hit = '0;
    for (int k = 0; k < NUM_USER; k++) begin
      if ({1'b0, instr} == ({1'b0, USER_BASE} + UW'(k)))
        user_hit[k] = 1'b1;
    end
  end

  always_comb begin
    sel_bypass = 1'b0;
    sel_extest = 1'b0;
    sel_idcode = 1'b0;
    sel_sample = 1'b0;
    sel_user   = '0;
    if (instr == ALL_ONES)
      sel_bypass = 1'b1;
    else if (instr == '0)
      sel_extest = 1'b1;
    else if (HAS_IDCODE && (instr == IDCODE_OP))
      sel_idcode = 1'b1;
    else if (instr == SAMPLE_OP)
      sel_sample = 1'b1;
    else if (user_hit != '0)
      sel_user = user_hit;
    else
      sel_bypass = 1'b1;
  end

  assign tdo    = shift_reg[0];
  assign tdo_en = shift_ir;

endmodule

// File: tb/tb_jtag_ir_decoder.sv
// Bench for jtag_ir_decoder: default 4-bit instance checked against a small
// reference model through a scoreboard, plus an 8-bit no-IDCODE instance.
module tb_jtag_ir_decoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, tlr, capture_ir, shift_ir, update_ir, tdi;
  logic [1:0] status_i;
  logic       tdo, tdo_en, sel_bypass, sel_extest, sel_idcode, sel_sample, len_err;
  logic [3:0] instr;
  logic [1:0] sel_user;

  logic       cap8, sh8, upd8, tdi8;
  logic [5:0] status8;
  logic       tdo8, tdo_en8, byp8, ext8, idc8, smp8, len8;
  logic [7:0] instr8;
  logic [1:0] user8;

  jtag_ir_decoder dut (
    .clock(clock), .reset(reset), .tlr(tlr), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .tdi(tdi), .status_i(status_i),
    .tdo(tdo), .tdo_en(tdo_en), .instr(instr), .sel_bypass(sel_bypass),
    .sel_extest(sel_extest), .sel_idcode(sel_idcode), .sel_sample(sel_sample),
    .sel_user(sel_user), .len_err(len_err)
  );

  jtag_ir_decoder #(
    .IR_WIDTH(8), .IDCODE_OP(8'h02), .SAMPLE_OP(8'h01), .USER_BASE(8'h80),
    .NUM_USER(2), .HAS_IDCODE(1'b0)
  ) dut8 (
    .clock(clock), .reset(reset), .tlr(tlr), .capture_ir(cap8),
    .shift_ir(sh8), .update_ir(upd8), .tdi(tdi8), .status_i(status8),
    .tdo(tdo8), .tdo_en(tdo_en8), .instr(instr8), .sel_bypass(byp8),
    .sel_extest(ext8), .sel_idcode(idc8), .sel_sample(smp8),
    .sel_user(user8), .len_err(len8)
  );

  typedef struct packed {
    logic       tdo;
    logic [3:0] instr;
    logic       len;
    logic [5:0] sel;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] m_sr, m_instr;
  int         m_cnt;
  logic       m_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {bypass, extest, idcode, sample, user[1:0]}
  function automatic logic [5:0] dec(input logic [3:0] i);
    case (i)
      4'b1111: return 6'b100000;
      4'b0000: return 6'b010000;
      4'b0010: return 6'b001000;
      4'b0001: return 6'b000100;
      4'b1000: return 6'b000001;
      4'b1001: return 6'b000010;
      default: return 6'b100000;
    endcase
  endfunction

  function automatic logic [5:0] sel_now();
    return {sel_bypass, sel_extest, sel_idcode, sel_sample, sel_user};
  endfunction

  task automatic model_reset();
    m_sr = 4'b0001; m_instr = 4'b0010; m_cnt = 0; m_len = 1'b0;
  endtask

  task automatic cyc(input bit t, input bit cap, input bit sh, input bit upd, input bit d);
    logic [3:0] old;
    exp_t e;
    tlr = t; capture_ir = cap; shift_ir = sh; update_ir = upd; tdi = d;
    old = m_sr;
    if (t) model_reset();
    else begin
      m_len = upd && (m_cnt != 4);
      if (upd) m_instr = old;
      if (cap) begin m_sr = {status_i, 2'b01}; m_cnt = 0; end
      else if (sh) begin m_sr = {d, m_sr[3:1]}; m_cnt = (m_cnt < 5) ? m_cnt + 1 : 5; end
    end
    e.tdo = m_sr[0]; e.instr = m_instr; e.len = m_len; e.sel = dec(m_instr);
    sb.push_back(e);
    #1 check("tdo_en", 32'(tdo_en), 32'(sh));
    @(posedge clock); #1;
    tlr = 0; capture_ir = 0; shift_ir = 0; update_ir = 0;
    e = sb.pop_front();
    check("tdo", 32'(tdo), 32'(e.tdo));
    check("instr", 32'(instr), 32'(e.instr));
    check("len_err", 32'(len_err), 32'(e.len));
    check("sel", 32'(sel_now()), 32'(e.sel));
  endtask

  task automatic load(input logic [3:0] v, input int n);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0, v[i % 4]);
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic cyc8(input bit cap, input bit sh, input bit upd, input bit d);
    cap8 = cap; sh8 = sh; upd8 = upd; tdi8 = d;
    @(posedge clock); #1;
    cap8 = 0; sh8 = 0; upd8 = 0;
  endtask

  initial begin
    logic [3:0] tdo_exp;
    reset = 1; tlr = 0; capture_ir = 0; shift_ir = 0; update_ir = 0; tdi = 0;
    status_i = 2'b10; cap8 = 0; sh8 = 0; upd8 = 0; tdi8 = 0; status8 = 6'h3F;
    #12;
    check("rst_instr", 32'(instr), 32'h2);
    check("rst_idcode", 32'(sel_idcode), 32'h1);
    check("rst_tdo", 32'(tdo), 32'h1);
    check("rst_len", 32'(len_err), 32'h0);
    check("rst8_instr", 32'(instr8), 32'hFF);
    check("rst8_bypass", 32'(byp8), 32'h1);
    @(posedge clock); #1 reset = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0);

    // capture status 10 then shift ones: tdo 1,0,0,1
    cyc(0, 1, 0, 0, 0);
    check("cap_tdo", 32'(tdo), 32'h1);
    tdo_exp = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 1);
      check("shift_tdo", 32'(tdo), 32'(tdo_exp[i]));
    end
    cyc(0, 0, 0, 1, 0);
    check("upd_instr", 32'(instr), 32'hF);
    check("upd_bypass", 32'(sel_bypass), 32'h1);
    check("upd_len", 32'(len_err), 32'h0);

    load(4'b1001, 4);
    check("user_sel", 32'(sel_user), 32'h2);
    load(4'b0101, 4);
    check("unassigned_bypass", 32'(sel_bypass), 32'h1);

    load(4'b1000, 3);
    check("short_len", 32'(len_err), 32'h1);
    cyc(0, 0, 0, 0, 0);
    check("short_len_pulse", 32'(len_err), 32'h0);
    load(4'b1000, 9);
    check("long_len", 32'(len_err), 32'h1);
    load(4'b1000, 4);
    check("user0_sel", 32'(sel_user), 32'h1);

    // update + capture in the same cycle
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, (i == 0));
    cyc(0, 1, 0, 1, 0);
    check("ovl_sample", 32'(sel_sample), 32'h1);
    check("ovl_tdo", 32'(tdo), 32'h1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("ovl_sr_bit2", 32'(tdo), 32'h0);
    cyc(0, 0, 1, 0, 0);
    check("ovl_sr_bit3", 32'(tdo), 32'h1);

    // tlr during shift, then count restarts from zero
    load(4'b1000, 4);
    cyc(0, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 1);
    check("tlr_instr", 32'(instr), 32'h2);
    cyc(0, 0, 0, 1, 0);
    check("tlr_cnt_zero", 32'(len_err), 32'h1);

    // asynchronous reset mid-shift
    load(4'b1000, 4);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    #2 reset = 1;
    #1;
    check("arst_instr", 32'(instr), 32'h2);
    check("arst_tdo", 32'(tdo), 32'h1);
    check("arst_idcode", 32'(sel_idcode), 32'h1);
    @(posedge clock); #1 reset = 0;
    model_reset();
    cyc(0, 0, 0, 0, 0);

    // 8-bit, no IDCODE instance
    check("w8_rst_instr", 32'(instr8), 32'hFF);
    cyc8(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc8(0, 1, 0, 0);
    cyc8(0, 0, 1, 0);
    check("w8_instr", 32'(instr8), 32'h00);
    check("w8_extest", 32'(ext8), 32'h1);
    check("w8_len", 32'(len8), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_ir_decoder.md
# jtag_ir_decoder

Parametrised JTAG instruction register with capture, shift and update stages, built-in opcode decode to one-hot data-register selects, and a shift-length checker. It sits between the TAP controller, which supplies the capture/shift/update strobes, and the data-register multiplexer, which consumes the selects. It is the width-generic, single-clock successor of the per-cell instruction register.

## Interface
Parameters:
- IR_WIDTH, 4: instruction length in bits; must be ≥ 2.
- IDCODE_OP, 4'b0010: IDCODE opcode; IR_WIDTH bits wide.
- SAMPLE_OP, 4'b0001: SAMPLE/PRELOAD opcode.
- USER_BASE, 4'b1000: first user opcode.
- NUM_USER, 2: number of consecutive user opcodes starting at USER_BASE; must be ≥ 1.
- HAS_IDCODE, 1: 1 makes IDCODE the reset instruction; 0 makes it BYPASS.

Ports:
- clock  in  1  TCK-domain clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset; the TRST equivalent.
- tlr  in  1  synchronous Test-Logic-Reset indication from the TAP.
- capture_ir  in  1  Capture-IR strobe.
- shift_ir  in  1  Shift-IR strobe.
- update_ir  in  1  Update-IR strobe.
- tdi  in  1  serial input.
- status_i  in  IR_WIDTH-2  status bits captured into the upper shift bits.
- tdo  out  1  serial output, equal to shift_reg[0].
- tdo_en  out  1  equal to shift_ir.
- instr  out  IR_WIDTH  current committed instruction.
- sel_bypass, sel_extest, sel_idcode, sel_sample  out  1 each  decoded selects.
- sel_user  out  NUM_USER  one-hot user select; bit k selects USER_BASE+k.
- len_err  out  1  single-cycle pulse flagging an update after a shift of the wrong length.

## Operation
- **State:**
  - shift_reg[IR_WIDTH-1:0].
  - instr[IR_WIDTH-1:0].
  - shift_cnt, a saturating counter of width clog2(IR_WIDTH+2) that saturates at IR_WIDTH+1.
- **Reset (async) or tlr=1:**
  - instr = IDCODE_OP if HAS_IDCODE, else all-ones.
  - shift_reg = {0…0, 2'b01}.
  - shift_cnt = 0.
  - len_err = 0.
  - tlr has priority over every strobe.
- **Capture** (capture_ir=1):
  - shift_reg ← {status_i, 2'b01}.
  - shift_cnt ← 0.
- **Shift** (shift_ir=1, capture_ir=0):
  - shift_reg ← {tdi, shift_reg[IR_WIDTH-1:1]}, so the LSB leaves first.
  - shift_cnt ← min(shift_cnt+1, IR_WIDTH+1).
- **Update** (update_ir=1):
  - instr ← shift_reg, using the value before the edge.
  - len_err ← 1 for one cycle if shift_cnt ≠ IR_WIDTH.
  - The instruction commits regardless of len_err.
- **Strobe priority and overlap:**
  - capture overrides shift on shift_reg.
  - update is independent of both and always samples the pre-edge shift_reg.
  - update with capture in the same cycle: instr takes the old shift_reg, and shift_reg takes the captured value.
- **Idle:** with no strobes asserted, all state holds.
- **Decode** (combinational from instr; exactly one select high at all times), first match wins:
  1. all-ones → sel_bypass.
  2. all-zeros → sel_extest.
  3. == IDCODE_OP with HAS_IDCODE=1 → sel_idcode.
  4. == SAMPLE_OP → sel_sample.
  5. USER_BASE ≤ instr < USER_BASE+NUM_USER (unsigned) → sel_user[instr-USER_BASE].
  6. anything else → sel_bypass.
- **Outputs:** tdo and tdo_en are combinational from shift_reg[0] and shift_ir, with no extra flop.

## Timing
- **Latency:**
  - Update-IR edge to the new select: 1 clock, meaning selects are valid in the cycle after update_ir is sampled.
  - tdo changes 1 clock after each shift edge.
- **Reset values:**
  - instr = IDCODE_OP (HAS_IDCODE=1) or all-ones.
  - sel_idcode = 1 (or sel_bypass = 1); all other selects 0.
  - tdo = 1, because shift_reg[0] = 1.
  - tdo_en = shift_ir.
  - len_err = 0.
- **Asynchronous reset:** asserting reset mid-shift clears shift_reg and instr immediately, without waiting for a clock. The first edge after release behaves as idle unless a strobe is present.
- **Shift counter:** saturates, so very long shifts never wrap back to IR_WIDTH.

## Test plan
- **Reset value:** reset pulse, no strobes → instr=4'b0010, sel_idcode=1, tdo=1, len_err=0.
- **Capture and shift-out:** status_i=2'b10; capture, then 4 shifts with tdi=1,1,1,1 → tdo sequence 1,0,0,1. Then update → instr=4'b1111, sel_bypass=1, len_err=0.
- **User select:** load 4'b1001 with 4 shifts, then update → sel_user=2'b10 one clock after update. Load 4'b0101 → sel_bypass=1 (unassigned opcode).
- **Length error:** 3 shifts then update → len_err pulses for exactly 1 cycle and instr is still committed. 9 shifts then update → len_err=1 (counter saturated).
- **Overlap and TLR:** update+capture in the same cycle → instr takes the old shift_reg and shift_reg = {status_i, 01}. tlr=1 during a shift → instr=IDCODE_OP next edge and shift_cnt=0.
- **Parametric:** IR_WIDTH=8, HAS_IDCODE=0 → reset gives instr=8'hFF and sel_bypass=1. Shifting 8'h00 then update → sel_extest=1.
